// File: rtl/dcache_ctrl_if.sv
// Core-side and memory-side handshake bundles for dcache_ctrl.
// Signal names are written from the controller's point of view.
interface dcache_core_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_we;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [DATA_WIDTH-1:0] i_req_wdata;
    logic                  o_rsp_valid;
    logic [DATA_WIDTH-1:0] o_rsp_rdata;

    modport master (
        output i_req_valid,
        output i_req_we,
        output i_req_addr,
        output i_req_wdata,
        input  o_req_ready,
        input  o_rsp_valid,
        input  o_rsp_rdata
    );

    modport slave (
        input  i_req_valid,
        input  i_req_we,
        input  i_req_addr,
        input  i_req_wdata,
        output o_req_ready,
        output o_rsp_valid,
        output o_rsp_rdata
    );
endinterface

interface dcache_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256
);
    logic                  o_mem_req_valid;
    logic                  i_mem_req_ready;
    logic                  o_mem_req_we;
    logic [ADDR_WIDTH-1:0] o_mem_req_addr;
    logic [LINE_BITS-1:0]  o_mem_req_data;
    logic                  i_mem_rsp_valid;
    logic [LINE_BITS-1:0]  i_mem_rsp_data;

    modport master (
        output o_mem_req_valid,
        output o_mem_req_we,
        output o_mem_req_addr,
        output o_mem_req_data,
        input  i_mem_req_ready,
        input  i_mem_rsp_valid,
        input  i_mem_rsp_data
    );

    modport slave (
        input  o_mem_req_valid,
        input  o_mem_req_we,
        input  o_mem_req_addr,
        input  o_mem_req_data,
        output i_mem_req_ready,
        output i_mem_rsp_valid,
        output i_mem_rsp_data
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Miss-handling controller for a direct-mapped data cache:
// lookup, store update, dirty writeback, line fill and replay.
module dcache_ctrl #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 32,
    parameter  int CACHE_SIZE = 1024,
    parameter  int LINE_SIZE  = 32,
    localparam int OFS        = $clog2(LINE_SIZE),
    localparam int IDX        = $clog2(CACHE_SIZE / LINE_SIZE),
    localparam int TAG        = ADDR_WIDTH - IDX - OFS,
    localparam int LW         = LINE_SIZE * 8
) (
    input  logic                  clk,
    input  logic                  rst,

    dcache_core_if.slave          core,

    output logic                  o_cache_re,
    output logic                  o_cache_we,
    output logic                  o_cache_fe,
    output logic                  o_cache_valid,
    output logic [OFS-1:0]        o_cache_offset,
    output logic [IDX-1:0]        o_cache_index,
    output logic [TAG-1:0]        o_cache_tag,
    output logic [LW-1:0]         o_cache_fdata,
    output logic [DATA_WIDTH-1:0] o_cache_wdata,
    input  logic                  i_cache_valid,
    input  logic                  i_cache_dirty,
    input  logic                  i_cache_hit,
    input  logic [TAG-1:0]        i_cache_tag,
    input  logic [LW-1:0]         i_cache_vdata,
    input  logic [DATA_WIDTH-1:0] i_cache_rdata,

    dcache_mem_if.master          mem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_COMPARE,
        S_WB_REQ,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_REFILL
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [ADDR_WIDTH-1:0] r_vic_addr;
    logic [LW-1:0]         r_vic_data;
    logic [LW-1:0]         r_fill;

    logic                  w_compare;
    logic                  w_hit;
    logic                  w_wb;
    logic                  w_fill_req;
    logic [ADDR_WIDTH-1:0] w_line_addr;

    assign w_compare   = (r_state == S_COMPARE);
    assign w_hit       = w_compare & i_cache_hit;
    assign w_wb        = (r_state == S_WB_REQ);
    assign w_fill_req  = (r_state == S_FILL_REQ);
    assign w_line_addr = {r_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_vic_addr <= '0;
            r_vic_data <= '0;
            r_fill     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (core.i_req_valid) begin
                        r_addr  <= core.i_req_addr;
                        r_we    <= core.i_req_we;
                        r_wdata <= core.i_req_wdata;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_state <= S_COMPARE;
                end
                S_COMPARE: begin
                    if (i_cache_hit) begin
                        r_state <= S_IDLE;
                    end else if (i_cache_valid && i_cache_dirty) begin
                        r_vic_addr <= {i_cache_tag,
                                       r_addr[OFS +: IDX],
                                       {OFS{1'b0}}};
                        r_vic_data <= i_cache_vdata;
                        r_state    <= S_WB_REQ;
                    end else begin
                        r_state <= S_FILL_REQ;
                    end
                end
                // Writebacks are posted: no response comes back.
                S_WB_REQ: begin
                    if (mem.i_mem_req_ready) begin
                        r_state <= S_FILL_REQ;
                    end
                end
                S_FILL_REQ: begin
                    if (mem.i_mem_req_ready) begin
                        r_state <= S_FILL_WAIT;
                    end
                end
                S_FILL_WAIT: begin
                    if (mem.i_mem_rsp_valid) begin
                        r_fill  <= mem.i_mem_rsp_data;
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    r_state <= S_LOOKUP;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core.o_req_ready = (r_state == S_IDLE);
    assign core.o_rsp_valid = w_hit;
    assign core.o_rsp_rdata = (w_hit && !r_we) ? i_cache_rdata : '0;

    assign o_cache_re     = (r_state == S_LOOKUP);
    assign o_cache_we     = w_hit & r_we;
    assign o_cache_fe     = (r_state == S_REFILL);
    assign o_cache_valid  = (r_state == S_REFILL);
    assign o_cache_offset = r_addr[OFS-1:0];
    assign o_cache_index  = r_addr[OFS +: IDX];
    assign o_cache_tag    = r_addr[ADDR_WIDTH-1 -: TAG];
    assign o_cache_fdata  = r_fill;
    assign o_cache_wdata  = r_wdata;

    // Request fields come only from registers, so they hold until accepted.
    assign mem.o_mem_req_valid = w_wb | w_fill_req;
    assign mem.o_mem_req_we    = w_wb;
    assign mem.o_mem_req_addr  = w_wb       ? r_vic_addr  :
                                 w_fill_req ? w_line_addr : '0;
    assign mem.o_mem_req_data  = w_wb ? r_vic_data : '0;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural cache,
// a stalling line memory and a response scoreboard.
module tb_dcache_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int LW  = 256;
    localparam int OFS = 5;
    localparam int IDX = 5;
    localparam int TAG = 22;
    localparam int NL  = 32;

    typedef struct {
        logic [DW-1:0] rd;
        int            lat;
        int            t;
    } exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } xfer_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dcache_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) core_if ();
    dcache_mem_if  #(.ADDR_WIDTH(AW), .LINE_BITS(LW))  mem_if ();

    logic           o_cache_re, o_cache_we, o_cache_fe, o_cache_valid;
    logic [OFS-1:0] o_cache_offset;
    logic [IDX-1:0] o_cache_index;
    logic [TAG-1:0] o_cache_tag;
    logic [LW-1:0]  o_cache_fdata;
    logic [DW-1:0]  o_cache_wdata;
    logic           i_cache_valid, i_cache_dirty, i_cache_hit;
    logic [TAG-1:0] i_cache_tag;
    logic [LW-1:0]  i_cache_vdata;
    logic [DW-1:0]  i_cache_rdata;

    dcache_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .core           (core_if),
        .o_cache_re     (o_cache_re),
        .o_cache_we     (o_cache_we),
        .o_cache_fe     (o_cache_fe),
        .o_cache_valid  (o_cache_valid),
        .o_cache_offset (o_cache_offset),
        .o_cache_index  (o_cache_index),
        .o_cache_tag    (o_cache_tag),
        .o_cache_fdata  (o_cache_fdata),
        .o_cache_wdata  (o_cache_wdata),
        .i_cache_valid  (i_cache_valid),
        .i_cache_dirty  (i_cache_dirty),
        .i_cache_hit    (i_cache_hit),
        .i_cache_tag    (i_cache_tag),
        .i_cache_vdata  (i_cache_vdata),
        .i_cache_rdata  (i_cache_rdata),
        .mem            (mem_if)
    );

    int n_chk = 0;
    int n_pass = 0;

    exp_t  sb[$];
    xfer_t q_act[$];

    int n_rsp = 0, n_fe = 0, n_fv = 0, n_we = 0, n_xfer = 0;
    int overlap = 0, stab_err = 0;
    int g_stall = 0, g_rsp = 3;
    bit spur_req = 0;

    logic           cv[NL], cdt[NL];
    logic [TAG-1:0] ct[NL];
    logic [LW-1:0]  cd[NL];
    logic [LW-1:0]  mem_img[int unsigned];

    task automatic chk(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base | 32'(i);
        return l;
    endfunction

    // Cache, memory and response monitor all act on the falling edge.
    initial begin : model
        bit            seen;
        int            cnt, ix, w, rsp_at;
        bit            rsp_pend;
        logic [LW-1:0] rsp_line;
        xfer_t         cap;
        logic [LW-1:0] l40;
        exp_t          e;
        seen = 0; cnt = 0; rsp_pend = 0; rsp_at = 0; rsp_line = '0;
        for (int i = 0; i < NL; i++) begin
            cv[i] = 0; cdt[i] = 0; ct[i] = '0; cd[i] = '0;
        end
        l40 = mk_line(32'h0040_0000);
        l40[31:0] = 32'hDEADBEEF;
        mem_img[32'h40]  = l40;
        mem_img[32'h440] = mk_line(32'h0440_0000);
        mem_img[32'h80]  = mk_line(32'h0080_0000);
        {i_cache_valid, i_cache_dirty, i_cache_hit} = 3'b000;
        i_cache_tag = '0; i_cache_vdata = '0; i_cache_rdata = '0;
        mem_if.i_mem_req_ready = 0;
        mem_if.i_mem_rsp_valid = 0;
        mem_if.i_mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (core_if.o_rsp_valid === 1'b1) begin
                n_rsp++;
                chk("rsp_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_rdata", core_if.o_rsp_rdata, e.rd);
                    chk("rsp_latency", cyc - e.t, e.lat);
                end
            end
            if (32'(o_cache_re) + 32'(o_cache_we) + 32'(o_cache_fe) > 1)
                overlap++;
            ix = int'(o_cache_index);
            w  = int'(o_cache_offset[4:2]);
            if (o_cache_re === 1'b1) begin
                i_cache_valid = cv[ix];
                i_cache_dirty = cdt[ix];
                i_cache_tag   = ct[ix];
                i_cache_vdata = cd[ix];
                i_cache_hit   = cv[ix] && (ct[ix] == o_cache_tag);
                i_cache_rdata = cd[ix][w*32 +: 32];
            end
            if (o_cache_we === 1'b1) begin
                n_we++;
                cd[ix][w*32 +: 32] = o_cache_wdata;
                cdt[ix] = 1;
            end
            if (o_cache_fe === 1'b1) begin
                n_fe++;
                if (o_cache_valid === 1'b1) n_fv++;
                cd[ix] = o_cache_fdata;
                ct[ix] = o_cache_tag;
                cv[ix] = 1;
                cdt[ix] = 0;
            end
            mem_if.i_mem_req_ready = 0;
            mem_if.i_mem_rsp_valid = 0;
            mem_if.i_mem_rsp_data  = '0;
            if (rst) begin
                seen = 0;
            end else if (mem_if.o_mem_req_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1;
                    cnt  = 0;
                    cap.we   = mem_if.o_mem_req_we;
                    cap.addr = mem_if.o_mem_req_addr;
                    cap.data = mem_if.o_mem_req_data;
                end else if (cap.we !== mem_if.o_mem_req_we ||
                             cap.addr !== mem_if.o_mem_req_addr ||
                             cap.data !== mem_if.o_mem_req_data) begin
                    stab_err++;
                end
                if (cnt == g_stall) begin
                    mem_if.i_mem_req_ready = 1;
                    seen = 0;
                    n_xfer++;
                    q_act.push_back(cap);
                    if (cap.we) begin
                        mem_img[cap.addr] = cap.data;
                    end else begin
                        rsp_pend = 1;
                        rsp_at   = cyc + g_rsp;
                        rsp_line = mem_img.exists(cap.addr) ?
                                   mem_img[cap.addr] : '0;
                    end
                end else begin
                    cnt++;
                end
            end
            if (rsp_pend && cyc == rsp_at) begin
                mem_if.i_mem_rsp_valid = 1;
                mem_if.i_mem_rsp_data  = rsp_line;
                rsp_pend = 0;
            end
            if (spur_req) begin
                mem_if.i_mem_rsp_valid = 1;
                mem_if.i_mem_rsp_data  = {8{32'hBAD0BAD0}};
                spur_req = 0;
            end
        end
    end

    task automatic do_req(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit track,
                          input logic [DW-1:0] exp_rd, input int exp_lat);
        int n;
        n = 0;
        @(negedge clk);
        while (core_if.o_req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", core_if.o_req_ready, 1);
        core_if.i_req_valid = 1;
        core_if.i_req_we    = we;
        core_if.i_req_addr  = addr;
        core_if.i_req_wdata = wdata;
        if (track) sb.push_back('{exp_rd, exp_lat, cyc});
        @(negedge clk);
        core_if.i_req_valid = 0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (n_rsp < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", n_rsp >= target, 1);
    endtask

    task automatic chk_xfer(input string tag, input logic we,
                            input logic [AW-1:0] addr,
                            input logic [LW-1:0] data);
        xfer_t x;
        chk({tag, "_present"}, q_act.size() > 0, 1);
        if (q_act.size() > 0) begin
            x = q_act.pop_front();
            chk({tag, "_we"}, x.we, we);
            chk({tag, "_addr"}, x.addr, addr);
            if (we) chk({tag, "_data"}, x.data, data);
        end
    endtask

    initial begin : main
        int            fe0, we0, x0, n;
        logic [LW-1:0] wb_line;
        rst = 1;
        core_if.i_req_valid = 0;
        core_if.i_req_we    = 0;
        core_if.i_req_addr  = '0;
        core_if.i_req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", core_if.o_req_ready, 1);
        chk("rst_rsp_valid", core_if.o_rsp_valid, 0);
        chk("rst_rsp_rdata", core_if.o_rsp_rdata, 0);
        chk("rst_mem_valid", mem_if.o_mem_req_valid, 0);
        chk("rst_mem_addr", mem_if.o_mem_req_addr, 0);
        chk("rst_cache_ctl", {o_cache_re, o_cache_we, o_cache_fe}, 0);
        chk("rst_cache_idx", o_cache_index, 0);
        rst = 0;

        // Cold miss, clean fill.
        fe0 = n_fe;
        do_req(0, 32'h40, '0, 1, 32'hDEADBEEF, 9);
        wait_rsp(1);
        chk("cold_fe_once", n_fe - fe0, 1);
        chk_xfer("cold_rd", 0, 32'h40, '0);

        x0 = n_xfer;
        do_req(0, 32'h44, '0, 1, 32'h0040_0001, 2);
        wait_rsp(2);
        chk("hit_no_mem", n_xfer - x0, 0);

        we0 = n_we;
        do_req(1, 32'h48, 32'h12345678, 1, 32'h0, 2);
        wait_rsp(3);
        chk("store_we_once", n_we - we0, 1);
        do_req(0, 32'h48, '0, 1, 32'h12345678, 2);
        wait_rsp(4);

        // Dirty conflict with stalled memory.
        g_stall = 4;
        wb_line = mk_line(32'h0040_0000);
        wb_line[31:0]  = 32'hDEADBEEF;
        wb_line[95:64] = 32'h12345678;
        do_req(0, 32'h440, '0, 1, 32'h0440_0000, 18);
        wait_rsp(5);
        chk_xfer("dirty_wb", 1, 32'h40, wb_line);
        chk_xfer("dirty_rd", 0, 32'h440, '0);
        g_stall = 0;

        // Stray response while idle.
        fe0 = n_fe;
        spur_req = 1;
        repeat (4) @(negedge clk);
        chk("spur_ready", core_if.o_req_ready, 1);
        chk("spur_mem_valid", mem_if.o_mem_req_valid, 0);
        chk("spur_no_fe", n_fe - fe0, 0);
        do_req(0, 32'h440, '0, 1, 32'h0440_0000, 2);
        wait_rsp(6);

        // Reset while waiting for fill data.
        g_rsp = 8;
        x0 = n_xfer;
        do_req(0, 32'h80, '0, 0, '0, 0);
        n = 0;
        while (n_xfer == x0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_rd_issued", n_xfer - x0, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_ready", core_if.o_req_ready, 1);
        chk("abort_mem_valid", mem_if.o_mem_req_valid, 0);
        rst = 0;
        fe0 = n_fe;
        repeat (12) @(negedge clk);
        chk("late_rsp_no_fe", n_fe - fe0, 0);
        chk("late_rsp_ready", core_if.o_req_ready, 1);
        chk_xfer("abort_rd", 0, 32'h80, '0);
        g_rsp = 3;
        do_req(0, 32'h8C, '0, 1, 32'h0080_0003, 9);
        wait_rsp(7);
        chk_xfer("refill_rd", 0, 32'h80, '0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("no_extra_xfer", q_act.size(), 0);
        chk("mem_stable", stab_err, 0);
        chk("ctl_exclusive", overlap, 0);
        chk("fe_with_valid", n_fv, n_fe);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Miss-handling controller between a core load/store port and the direct-mapped `cache` block (DATA and TAG RAMs plus per-index valid/dirty state).
- Sequences lookup, store update, dirty-victim writeback, line fill from a line-wide memory port, and replay.
- One request is outstanding at a time; the block is not pipelined.

Parameters:
- DATA_WIDTH, 32, core word width in bits.
- ADDR_WIDTH, 32, byte address width.
- CACHE_SIZE, 1024, cache capacity in bytes; must match the attached cache.
- LINE_SIZE, 32, line size in bytes.
- Derived: OFS = clog2(LINE_SIZE), IDX = clog2(CACHE_SIZE/LINE_SIZE), TAG = ADDR_WIDTH-IDX-OFS, LW = LINE_SIZE*8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_req_valid  in  1  core request valid.
- o_req_ready  out  1  controller can accept a request.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  ADDR_WIDTH  byte address; the word must not cross a line.
- i_req_wdata  in  DATA_WIDTH  store data.
- o_rsp_valid  out  1  one-cycle completion pulse (loads and stores).
- o_rsp_rdata  out  DATA_WIDTH  load data; 0 for stores.
- o_cache_re, o_cache_we, o_cache_fe, o_cache_valid  out  1 each  cache controls.
- o_cache_offset / o_cache_index / o_cache_tag  out  OFS / IDX / TAG  fields of the latched address.
- o_cache_fdata  out  LW  fill line.
- o_cache_wdata  out  DATA_WIDTH  store word.
- i_cache_valid, i_cache_dirty, i_cache_hit  in  1 each  cache status.
- i_cache_tag  in  TAG  victim tag.
- i_cache_vdata  in  LW  victim line.
- i_cache_rdata  in  DATA_WIDTH  read word.
- o_mem_req_valid  out  1  memory request valid.
- i_mem_req_ready  in  1  memory accepts the request.
- o_mem_req_we  out  1  1 = writeback, 0 = line read.
- o_mem_req_addr  out  ADDR_WIDTH  line-aligned address (offset bits 0).
- o_mem_req_data  out  LW  writeback line.
- i_mem_rsp_valid  in  1  fill data valid.
- i_mem_rsp_data  in  LW  fill line.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0, except o_req_ready = 1.
  - Latched address/data registers cleared.
  - A reset in any state aborts the operation, drops o_mem_req_valid, and discards any later i_mem_rsp_valid.
- States: IDLE, LOOKUP, COMPARE, WB_REQ, FILL_REQ, FILL_WAIT, REFILL.
- IDLE:
  - o_req_ready = 1 only in IDLE.
  - On i_req_valid: latch addr/we/wdata, go to LOOKUP.
- LOOKUP:
  - o_cache_re = 1 with the index/tag/offset from the latched address.
  - Go to COMPARE. Cache status is valid one cycle after the read.
- COMPARE:
  - Hit, load: o_rsp_valid = 1, o_rsp_rdata = i_cache_rdata; go to IDLE.
  - Hit, store: o_cache_we = 1 and o_cache_wdata = latched wdata in this same cycle; o_rsp_valid = 1; go to IDLE.
  - Miss with i_cache_valid & i_cache_dirty: capture {i_cache_tag, index, 0} and i_cache_vdata into the victim registers; go to WB_REQ.
  - Any other miss: go to FILL_REQ.
- WB_REQ:
  - o_mem_req_valid = 1, we = 1, addr/data from the victim registers.
  - On i_mem_req_ready, go to FILL_REQ. No response is expected for a writeback.
- FILL_REQ:
  - o_mem_req_valid = 1, we = 0, addr = line-aligned latched address.
  - On ready, go to FILL_WAIT.
- FILL_WAIT:
  - On i_mem_rsp_valid, capture i_mem_rsp_data and go to REFILL.
  - i_mem_rsp_valid in any other state is ignored.
- REFILL:
  - o_cache_fe = 1, o_cache_valid = 1, o_cache_fdata = captured line.
  - Go to LOOKUP (replay). The replay must hit.
- Memory handshake:
  - o_mem_req_valid and its addr/we/data stay stable until accepted.
  - Transfer happens on the cycle valid & ready are both high.
  - Ready may be high in the same cycle valid rises.
- Cache control rules:
  - o_cache_re/we/fe are mutually exclusive and never asserted outside the states listed above.
  - o_cache_offset/index/tag always reflect the latched request.
- Latency, counted from the accept cycle T:
  - Hit: o_rsp_valid at T+2.
  - Clean miss with memory ready and response R cycles after acceptance: FILL_REQ at T+3, REFILL at T+4+R, o_rsp_valid at T+6+R.
  - A dirty miss adds the WB_REQ cycles, including any ready stalls.
- A back-to-back request may be accepted in the cycle after o_rsp_valid.

Test Plan:
- Cold load, 0x40 (idx 2, tag 0):
  - Expect a memory read at addr 0x40.
  - Return a line with word 0 = 0xDEADBEEF, rsp 3 cycles after acceptance.
  - Expect o_cache_fe once, then o_rsp_valid with rdata 0xDEADBEEF at T+9.
- Load hit to 0x44 after the fill:
  - o_rsp_valid exactly 2 cycles after acceptance.
  - No memory request issued.
- Store 0x12345678 to 0x48 (hit), then load 0x48:
  - Store: o_cache_we pulses once in COMPARE.
  - Load returns 0x12345678.
- Dirty conflict load 0x440 (idx 2, tag 1):
  - First request: writeback, we = 1, addr 0x40, data holding 0x12345678 at byte 8.
  - Then a read of 0x440.
  - Hold i_mem_req_ready low for 4 cycles on each request; addr/data must stay stable throughout.
- Robustness:
  - Spurious i_mem_rsp_valid in IDLE has no effect.
  - rst asserted during FILL_WAIT: next cycle IDLE, o_req_ready = 1, o_mem_req_valid = 0.
  - The late response is ignored, and a new request completes normally.
